// File: rtl/pc_src_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_src_ctrl
// Description : Multicycle sequencer selecting the PC source and producing
//               PC, IR and EPC write enables plus the exception cause.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_src_ctrl #(
    parameter int EXC_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_ready,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 alu_zero,
    input  logic                 alu_overflow,
    input  logic                 ex_done,
    output logic [2:0]           pc_src,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 epc_write,
    output logic [EXC_WIDTH-1:0] cause,
    output logic                 busy
);

    localparam logic [2:0] c_FETCH    = 3'd0;
    localparam logic [2:0] c_DECODE   = 3'd1;
    localparam logic [2:0] c_EXEC     = 3'd2;
    localparam logic [2:0] c_EXC_SAVE = 3'd3;
    localparam logic [2:0] c_EXC_VEC  = 3'd4;

    localparam logic [2:0] c_SRC_SEQ    = 3'b000;
    localparam logic [2:0] c_SRC_BRANCH = 3'b001;
    localparam logic [2:0] c_SRC_JUMP   = 3'b010;
    localparam logic [2:0] c_SRC_EPC    = 3'b011;
    localparam logic [2:0] c_SRC_VECTOR = 3'b100;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_RTE   = 6'h10;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FN_JR    = 6'h08;

    localparam logic [EXC_WIDTH-1:0] c_CAUSE_ILLEGAL  = EXC_WIDTH'(0);
    localparam logic [EXC_WIDTH-1:0] c_CAUSE_OVERFLOW = EXC_WIDTH'(1);

    logic [2:0]           r_state;
    logic [2:0]           w_nextState;
    logic [EXC_WIDTH-1:0] r_cause;
    logic [EXC_WIDTH-1:0] w_causeNext;
    logic                 w_causeLoad;
    logic                 w_legal;
    logic [2:0]           w_pcSrc;
    logic                 w_pcWrite;
    logic                 w_irWrite;
    logic                 w_epcWrite;

    always_comb begin
        w_legal = 1'b0;
        case (opcode)
            c_OP_RTYPE, c_OP_J, c_OP_JAL, c_OP_BEQ, c_OP_BNE,
            c_OP_RTE, c_OP_ADDI, c_OP_LW, c_OP_SW: w_legal = 1'b1;
            default:                               w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        w_causeLoad = 1'b0;
        w_causeNext = r_cause;
        w_pcSrc     = c_SRC_SEQ;
        w_pcWrite   = 1'b0;
        w_irWrite   = 1'b0;
        w_epcWrite  = 1'b0;
        case (r_state)
            c_FETCH: begin
                if (mem_ready) begin
                    w_irWrite   = 1'b1;
                    w_pcWrite   = 1'b1;
                    w_nextState = c_DECODE;
                end
            end
            c_DECODE: begin
                if (!w_legal) begin
                    w_causeLoad = 1'b1;
                    w_causeNext = c_CAUSE_ILLEGAL;
                    w_nextState = c_EXC_SAVE;
                end else begin
                    w_nextState = c_EXEC;
                end
            end
            c_EXEC: begin
                case (opcode)
                    c_OP_J, c_OP_JAL: begin
                        w_pcWrite   = 1'b1;
                        w_pcSrc     = c_SRC_JUMP;
                        w_nextState = c_FETCH;
                    end
                    c_OP_BEQ, c_OP_BNE: begin
                        // bne takes the branch on the inverted zero flag
                        if (alu_zero ^ (opcode == c_OP_BNE)) begin
                            w_pcWrite = 1'b1;
                            w_pcSrc   = c_SRC_BRANCH;
                        end
                        w_nextState = c_FETCH;
                    end
                    c_OP_RTE: begin
                        w_pcWrite   = 1'b1;
                        w_pcSrc     = c_SRC_EPC;
                        w_nextState = c_FETCH;
                    end
                    default: begin
                        if ((opcode == c_OP_RTYPE) && (funct == c_FN_JR)) begin
                            w_pcWrite   = 1'b1;
                            w_nextState = c_FETCH;
                        end else if (ex_done) begin
                            if (alu_overflow) begin
                                w_causeLoad = 1'b1;
                                w_causeNext = c_CAUSE_OVERFLOW;
                                w_nextState = c_EXC_SAVE;
                            end else begin
                                w_nextState = c_FETCH;
                            end
                        end
                    end
                endcase
            end
            c_EXC_SAVE: begin
                w_epcWrite  = 1'b1;
                w_nextState = c_EXC_VEC;
            end
            c_EXC_VEC: begin
                if (mem_ready) begin
                    w_pcWrite   = 1'b1;
                    w_pcSrc     = c_SRC_VECTOR;
                    w_nextState = c_FETCH;
                end
            end
            default: w_nextState = c_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_FETCH;
            r_cause <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_causeLoad) begin
                r_cause <= w_causeNext;
            end
        end
    end

    // Reset forces every output low within the same cycle, including cause.
    assign pc_src    = reset ? 3'b000 : w_pcSrc;
    assign pc_write  = w_pcWrite & ~reset;
    assign ir_write  = w_irWrite & ~reset;
    assign epc_write = w_epcWrite & ~reset;
    assign cause     = reset ? '0 : r_cause;
    assign busy      = ~reset & (r_state != c_FETCH);

endmodule
`default_nettype wire

// File: tb/tb_pc_src_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_src_ctrl
// Description : Scoreboard bench for pc_src_ctrl with an instruction-level
//               reference model and randomized instruction streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_src_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       alu_zero = 1'b0;
    logic       alu_overflow = 1'b0;
    logic       ex_done = 1'b0;
    logic [2:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       epc_write;
    logic [1:0] cause;
    logic       busy;

    pc_src_ctrl #(.EXC_WIDTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_ready    (mem_ready),
        .opcode       (opcode),
        .funct        (funct),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .ex_done      (ex_done),
        .pc_src       (pc_src),
        .pc_write     (pc_write),
        .ir_write     (ir_write),
        .epc_write    (epc_write),
        .cause        (cause),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         cyc;
        logic [2:0] src;
        logic       pw;
        logic       iw;
        logic       ew;
    } ev_t;

    typedef struct packed {
        int         cyc;
        logic       busy;
        logic [1:0] cause;
    } st_t;

    ev_t  evQ[$];
    st_t  stQ[$];
    int   cycNum = 0;
    int   nChecks = 0;
    int   nErrors = 0;
    logic [1:0] mCause = 2'd0;

    always @(posedge clk) cycNum <= cycNum + 1;

    // Monitor: compares status every cycle and write events whenever the DUT raises an enable.
    always @(negedge clk) begin
        st_t s;
        ev_t e;
        if (stQ.size() > 0) begin
            s = stQ.pop_front();
            nChecks++;
            if (s.cyc != cycNum || busy !== s.busy || cause !== s.cause) begin
                nErrors++;
                $display("FAIL status cyc=%0d: got busy=%b cause=%0d, expected busy=%b cause=%0d (stamp %0d)",
                         cycNum, busy, cause, s.busy, s.cause, s.cyc);
            end
        end
        if (pc_write || ir_write || epc_write) begin
            nChecks++;
            if (evQ.size() == 0) begin
                nErrors++;
                $display("FAIL event cyc=%0d: unexpected pw=%b iw=%b ew=%b src=%0d, expected no write",
                         cycNum, pc_write, ir_write, epc_write, pc_src);
            end else begin
                e = evQ.pop_front();
                if (e.cyc != cycNum || pc_write !== e.pw || ir_write !== e.iw ||
                    epc_write !== e.ew || pc_src !== e.src) begin
                    nErrors++;
                    $display("FAIL event cyc=%0d: got pw=%b iw=%b ew=%b src=%0d, expected pw=%b iw=%b ew=%b src=%0d at cyc %0d",
                             cycNum, pc_write, ir_write, epc_write, pc_src, e.pw, e.iw, e.ew, e.src, e.cyc);
                end
            end
        end
    end

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic bit isLegal(input logic [5:0] opc);
        return opc inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h10, 6'h08, 6'h23, 6'h2B};
    endfunction

    task automatic step(input logic rst, input logic mr, input logic zero, input logic ovf,
                        input logic done, input logic eBusy, input logic ePw, input logic eIw,
                        input logic eEw, input logic [2:0] eSrc);
        reset        = rst;
        mem_ready    = mr;
        alu_zero     = zero;
        alu_overflow = ovf;
        ex_done      = done;
        stQ.push_back('{cyc: cycNum, busy: eBusy, cause: (rst ? 2'd0 : mCause)});
        if (ePw || eIw || eEw)
            evQ.push_back('{cyc: cycNum, src: eSrc, pw: ePw, iw: eIw, ew: eEw});
        @(posedge clk);
        #1;
    endtask

    // Exception tail: EPC save then handler vector; optionally cut short by reset.
    task automatic excSeq(input int vecWait, input bit abortVec);
        step(1'b0, rb(), rb(), rb(), rb(), 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        repeat (vecWait) step(1'b0, 1'b0, rb(), rb(), rb(), 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        if (abortVec) begin
            step(1'b1, 1'b1, rb(), rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
            mCause = 2'd0;
            step(1'b0, 1'b0, rb(), rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        end else begin
            step(1'b0, 1'b1, rb(), rb(), rb(), 1'b1, 1'b1, 1'b0, 1'b0, 3'd4);
        end
    endtask

    task automatic doInstr(input logic [5:0] opc, input logic [5:0] fn, input logic zero,
                           input logic ovf, input int fetchWait, input int exDelay,
                           input int vecWait, input bit abortVec);
        bit taken;
        opcode = opc;
        funct  = fn;
        repeat (fetchWait) step(1'b0, 1'b0, rb(), rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b1, rb(), rb(), rb(), 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        step(1'b0, rb(), rb(), rb(), rb(), 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        if (!isLegal(opc)) begin
            mCause = 2'd0;
            excSeq(vecWait, abortVec);
            return;
        end
        if (opc == 6'h02 || opc == 6'h03) begin
            step(1'b0, rb(), zero, rb(), rb(), 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
        end else if (opc == 6'h04 || opc == 6'h05) begin
            taken = (opc == 6'h04) ? zero : !zero;
            step(1'b0, rb(), zero, rb(), rb(), 1'b1, taken, 1'b0, 1'b0, taken ? 3'd1 : 3'd0);
        end else if (opc == 6'h10) begin
            step(1'b0, rb(), zero, rb(), rb(), 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
        end else if (opc == 6'h00 && fn == 6'h08) begin
            step(1'b0, rb(), zero, rb(), rb(), 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        end else begin
            repeat (exDelay) step(1'b0, rb(), rb(), rb(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
            step(1'b0, rb(), rb(), ovf, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
            if (ovf) begin
                mCause = 2'd1;
                excSeq(vecWait, abortVec);
            end
        end
    endtask

    logic [5:0] opTable [12];

    initial begin
        opTable = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h10,
                    6'h08, 6'h23, 6'h2B, 6'h3F, 6'h01, 6'h2A};
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

        doInstr(6'h04, 6'h11, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        doInstr(6'h04, 6'h11, 1'b0, 1'b0, 1, 0, 0, 1'b0);
        doInstr(6'h02, 6'h00, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        doInstr(6'h10, 6'h00, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        doInstr(6'h3F, 6'h00, 1'b0, 1'b0, 0, 0, 3, 1'b0);
        doInstr(6'h08, 6'h00, 1'b0, 1'b1, 0, 4, 1, 1'b0);
        doInstr(6'h08, 6'h00, 1'b0, 1'b0, 0, 4, 0, 1'b0);
        doInstr(6'h00, 6'h08, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        doInstr(6'h05, 6'h00, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        doInstr(6'h05, 6'h00, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        doInstr(6'h03, 6'h00, 1'b0, 1'b0, 2, 0, 0, 1'b0);
        doInstr(6'h23, 6'h00, 1'b0, 1'b0, 0, 2, 0, 1'b0);
        doInstr(6'h00, 6'h20, 1'b0, 1'b1, 0, 1, 2, 1'b0);
        doInstr(6'h2B, 6'h00, 1'b0, 1'b1, 0, 0, 0, 1'b1);
        doInstr(6'h02, 6'h00, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        for (int i = 0; i < 250; i++) begin
            logic [5:0] opc;
            logic [5:0] fn;
            opc = opTable[$urandom_range(0, 11)];
            fn  = rb() ? 6'h08 : 6'($urandom_range(0, 63));
            doInstr(opc, fn, rb(), rb(), $urandom_range(0, 3), $urandom_range(0, 5),
                    $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
        end

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        nChecks++;
        if (evQ.size() != 0 || stQ.size() != 0) begin
            nErrors++;
            $display("FAIL drain: %0d write events and %0d status entries left, expected 0 and 0",
                     evQ.size(), stQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
